// File: rtl/txtd_param.sv
// txtd_param: parametrised text-mode video generator.
//
// A single pixel-clock timing generator drives hsync/vsync. Character and attribute
// words come from an external screen RAM, and glyph rows come from an external font
// ROM. Both are 1-cycle synchronous read ports. Each pixel goes through a 16-colour
// palette to RGB565, with per-character blink and an underline cursor. Latency from
// the counters to the pins is a fixed 3 clocks, and sync is delayed by the same amount.
//
// Ports:
//   pixel_clock  in   pixel clock, all logic on rising edge
//   reset_n      in   asynchronous active-low reset
//   cursor_en    in   cursor enable
//   cursor_col   in   cursor text column
//   cursor_row   in   cursor text row
//   scr_rdaddr   out  screen RAM address (combinational from counters)
//   scr_rddata   in   screen word: [7:0] char, [11:8] fg, [14:12] bg, [15] blink
//   fnt_rdaddr   out  font ROM address {char, glyph_line}
//   fnt_rddata   in   glyph row, bit 7 = leftmost pixel
//   hsync/vsync  out  registered sync, active level HS_POL/VS_POL
//   r, g, b      out  RGB565 pixel, zero outside active video
//   visible      out  active-video flag
//   vblank       out  high while in the vertical blanking lines
module txtd_param #(
  parameter int unsigned H_ACTIVE   = 1440,
  parameter int unsigned H_FP       = 80,
  parameter int unsigned H_SYNC     = 152,
  parameter int unsigned H_BP       = 232,
  parameter int unsigned V_ACTIVE   = 900,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 25,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned GLYPH_LOG2 = 4,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned COLS       = 90,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned BLINK_LOG2 = 5
) (
  input  logic                    pixel_clock,
  input  logic                    reset_n,
  input  logic                    cursor_en,
  input  logic [7:0]              cursor_col,
  input  logic [7:0]              cursor_row,
  output logic [ADDR_W-1:0]       scr_rdaddr,
  input  logic [15:0]             scr_rddata,
  output logic [7+GLYPH_LOG2:0]   fnt_rdaddr,
  input  logic [7:0]              fnt_rddata,
  output logic                    hsync,
  output logic                    vsync,
  output logic [4:0]              r,
  output logic [5:0]              g,
  output logic [4:0]              b,
  output logic                    visible,
  output logic                    vblank
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PC_W    = $clog2(H_TOTAL);
  localparam int unsigned LC_W    = $clog2(V_TOTAL);
  localparam int unsigned FC_W    = BLINK_LOG2 + 1;

  // Timing counters and text position
  logic [PC_W-1:0]       pixel_count;
  logic [LC_W-1:0]       line_count;
  logic [FC_W-1:0]       frame_cnt;
  logic [GLYPH_LOG2-1:0] glyph_line;
  logic [ADDR_W-1:0]     row_base;
  logic [7:0]            text_row;

  // T0 combinational terms
  logic            pix_end, line_end, in_active_v;
  logic [PC_W-1:0] col_full;
  logic            vis0, hs0, vs0, vb0, cur0, blink_ph0;
  logic [2:0]      px_idx0;

  // Stage 1 (font address formed this stage)
  logic                  vis1, hs1, vs1, vb1, cur1, blink_ph1;
  logic [2:0]            px_idx1;
  logic [GLYPH_LOG2-1:0] gl1;

  // Stage 2 (glyph row arrives this stage)
  logic       vis2, hs2, vs2, vb2, cur2, blink_ph2, blink_attr2;
  logic [2:0] px_idx2;
  logic [3:0] fg2;
  logic [2:0] bg2;

  // T2 pixel select and palette
  logic       pix_bit, pix_on;
  logic [3:0] idx;
  logic [4:0] r_pal, b_pal;
  logic [5:0] g_pal;

  always_comb begin
    pix_end     = pixel_count == PC_W'(H_TOTAL - 1);
    line_end    = line_count == LC_W'(V_TOTAL - 1);
    in_active_v = line_count < LC_W'(V_ACTIVE);
    col_full    = pixel_count >> (3 + SCALE_LOG2);
    scr_rdaddr  = row_base + ADDR_W'(col_full);
    vis0        = (pixel_count < PC_W'(H_ACTIVE)) && in_active_v;
    hs0 = ((pixel_count >= PC_W'(H_ACTIVE + H_FP)) &&
           (pixel_count < PC_W'(H_ACTIVE + H_FP + H_SYNC))) ? HS_POL : ~HS_POL;
    vs0 = ((line_count >= LC_W'(V_ACTIVE + V_FP)) &&
           (line_count < LC_W'(V_ACTIVE + V_FP + V_SYNC))) ? VS_POL : ~VS_POL;
    vb0       = ~in_active_v;
    blink_ph0 = frame_cnt[BLINK_LOG2];
    px_idx0   = 3'(pixel_count >> SCALE_LOG2);
    // Underline cursor on the bottom two glyph lines; it blinks with the same phase.
    cur0 = cursor_en && (16'(col_full) == 16'(cursor_col)) && (text_row == cursor_row) &&
           (glyph_line >= GLYPH_LOG2'((1 << GLYPH_LOG2) - 2)) && !blink_ph0;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_count <= '0;
      line_count  <= '0;
      frame_cnt   <= '0;
      glyph_line  <= '0;
      row_base    <= '0;
      text_row    <= '0;
    end else if (pix_end) begin
      pixel_count <= '0;
      if (line_end) begin
        // Frame wrap wins over the row advance on the final pixel.
        line_count <= '0;
        frame_cnt  <= frame_cnt + FC_W'(1);
        glyph_line <= '0;
        row_base   <= '0;
        text_row   <= '0;
      end else begin
        line_count <= line_count + LC_W'(1);
        if (in_active_v) begin
          glyph_line <= glyph_line + GLYPH_LOG2'(1);
          if (glyph_line == '1) begin
            row_base <= row_base + ADDR_W'(COLS);
            text_row <= text_row + 8'd1;
          end
        end
      end
    end else begin
      pixel_count <= pixel_count + PC_W'(1);
    end
  end

  assign fnt_rdaddr = {scr_rddata[7:0], gl1};

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      vis1 <= 1'b0;  hs1 <= ~HS_POL;  vs1 <= ~VS_POL;  vb1 <= 1'b0;
      cur1 <= 1'b0;  blink_ph1 <= 1'b0;  px_idx1 <= '0;  gl1 <= '0;
      vis2 <= 1'b0;  hs2 <= ~HS_POL;  vs2 <= ~VS_POL;  vb2 <= 1'b0;
      cur2 <= 1'b0;  blink_ph2 <= 1'b0;  blink_attr2 <= 1'b0;  px_idx2 <= '0;
      fg2  <= '0;    bg2 <= '0;
    end else begin
      vis1 <= vis0;  hs1 <= hs0;  vs1 <= vs0;  vb1 <= vb0;
      cur1 <= cur0;  blink_ph1 <= blink_ph0;  px_idx1 <= px_idx0;  gl1 <= glyph_line;
      vis2 <= vis1;  hs2 <= hs1;  vs2 <= vs1;  vb2 <= vb1;
      cur2 <= cur1;  blink_ph2 <= blink_ph1;  px_idx2 <= px_idx1;
      blink_attr2 <= scr_rddata[15];
      fg2         <= scr_rddata[11:8];
      bg2         <= scr_rddata[14:12];
    end
  end

  always_comb begin
    pix_bit = fnt_rddata[3'd7 - px_idx2];
    pix_on  = (pix_bit & ~(blink_attr2 & blink_ph2)) | cur2;
    idx     = pix_on ? fg2 : {1'b0, bg2};
    // idx = {I, R, G, B}
    r_pal = idx[2] ? (idx[3] ? 5'd31 : 5'd21) : (idx[3] ? 5'd10 : 5'd0);
    g_pal = idx[1] ? (idx[3] ? 6'd63 : 6'd42) : (idx[3] ? 6'd21 : 6'd0);
    b_pal = idx[0] ? (idx[3] ? 5'd31 : 5'd21) : (idx[3] ? 5'd10 : 5'd0);
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
      r       <= '0;
      g       <= '0;
      b       <= '0;
      visible <= 1'b0;
      vblank  <= 1'b0;
    end else begin
      hsync   <= hs2;
      vsync   <= vs2;
      visible <= vis2;
      vblank  <= vb2;
      r       <= vis2 ? r_pal : 5'd0;
      g       <= vis2 ? g_pal : 6'd0;
      b       <= vis2 ? b_pal : 5'd0;
    end
  end

endmodule

// File: tb/tb_txtd_param.sv
// Bench for txtd_param in a small timing configuration. A position-based model
// derives every output from the frame geometry, RAM/ROM contents and cursor inputs.
module tb_txtd_param;
  localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 16, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;  // 40
  localparam int VT = VA + VFP + VSY + VBP;  // 20
  localparam int FR = HT * VT;               // 800 clocks per frame
  localparam int NCOLS = 4, GH = 8;

  logic        clk = 1'b0, rst_n = 1'b1, cen = 1'b0;
  logic [7:0]  ccol = 8'd0, crow = 8'd0;
  logic [12:0] scr_rdaddr;
  logic [15:0] scr_rddata;
  logic [10:0] fnt_rdaddr;
  logic [7:0]  fnt_rddata;
  logic        hsync, vsync, visible, vblank;
  logic [4:0]  r, b;
  logic [5:0]  g;

  logic [15:0] ram  [0:8191];
  logic [7:0]  font [0:2047];
  int checks = 0, failures = 0, edges = 0, vis_cnt = 0;
  bit first_run = 1'b1;

  txtd_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .GLYPH_LOG2(3), .SCALE_LOG2(0),
    .COLS(NCOLS), .ADDR_W(13), .BLINK_LOG2(1)
  ) dut (
    .pixel_clock(clk), .reset_n(rst_n), .cursor_en(cen), .cursor_col(ccol),
    .cursor_row(crow), .scr_rdaddr(scr_rdaddr), .scr_rddata(scr_rddata),
    .fnt_rdaddr(fnt_rdaddr), .fnt_rddata(fnt_rddata), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .visible(visible), .vblank(vblank)
  );

  initial forever #5 clk = ~clk;

  // Synchronous memories with one clock of read latency
  always @(posedge clk) begin
    scr_rddata <= ram[scr_rdaddr];
    fnt_rddata <= font[fnt_rdaddr];
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
    end
  endtask

  function automatic void pal(input logic [3:0] idx, output int rr, output int gg,
                              output int bb);
    rr = idx[2] ? (idx[3] ? 31 : 21) : (idx[3] ? 10 : 0);
    gg = idx[1] ? (idx[3] ? 63 : 42) : (idx[3] ? 21 : 0);
    bb = idx[0] ? (idx[3] ? 31 : 21) : (idx[3] ? 10 : 0);
  endfunction

  // Outputs for screen position p (clocks since the frame sequence started)
  function automatic void model(input int p, output int vis, output int hs, output int vs,
                                output int vb, output int rr, output int gg, output int bb);
    int pix, ln, fr, col, trow, gl;
    logic [15:0] word;
    logic [7:0]  row8;
    logic [3:0]  idx;
    bit on, blink_off;
    pix = p % HT;  ln = (p / HT) % VT;  fr = (p / FR) % 4;
    vis = (pix < HA && ln < VA) ? 1 : 0;
    hs  = (pix >= HA + HFP && pix < HA + HFP + HSY) ? 1 : 0;
    vs  = (ln >= VA + VFP && ln < VA + VFP + VSY) ? 1 : 0;
    vb  = (ln >= VA) ? 1 : 0;
    rr = 0;  gg = 0;  bb = 0;
    if (vis == 1) begin
      col = pix / 8;  trow = ln / GH;  gl = ln % GH;
      word = ram[trow * NCOLS + col];
      row8 = font[int'(word[7:0]) * GH + gl];
      blink_off = (fr >= 2);
      on = row8[7 - pix % 8] && !(word[15] && blink_off);
      if (cen && int'(ccol) == col && int'(crow) == trow && gl >= GH - 2 && !blink_off)
        on = 1'b1;
      idx = on ? word[11:8] : {1'b0, word[14:12]};
      pal(idx, rr, gg, bb);
    end
  endfunction

  function automatic int exp_addr(input int p);
    int pix, ln;
    pix = p % HT;  ln = (p / HT) % VT;
    return ((ln < VA ? ln : VA) / GH) * NCOLS + pix / 8;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int ev, eh, es, eb, er, eg, ebl;
    if (!rst_n || edges < 3) begin
      chk("rst_visible", int'(visible), 0);
      chk("rst_hsync", int'(hsync), 0);
      chk("rst_vsync", int'(vsync), 0);
      chk("rst_vblank", int'(vblank), 0);
      chk("rst_rgb", int'({r, g, b}), 0);
    end else begin
      model(edges - 3, ev, eh, es, eb, er, eg, ebl);
      chk("visible", int'(visible), ev);
      chk("hsync", int'(hsync), eh);
      chk("vsync", int'(vsync), es);
      chk("vblank", int'(vblank), eb);
      chk("r", int'(r), er);
      chk("g", int'(g), eg);
      chk("b", int'(b), ebl);
    end
    if (rst_n) chk("scr_rdaddr", int'(scr_rdaddr), exp_addr(edges));
    if (rst_n && first_run && edges >= 3 && edges <= FR + 2 && visible) vis_cnt++;
  end

  task automatic at_edge(input int e);
    int guard = 0;
    while (edges < e && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) chk("wait_timeout", edges, e);
  endtask

  // 0: word=addr|fg C, font 0x80; 1: 0x1F41, rows 0-3 0xFF else 0x00;
  // 2: blinking 0x9F41, font 0xFF; 3: 0x1F41, font 0x00, cursor at col 2 row 1
  task automatic set_phase(input int ph);
    for (int a = 0; a < 8; a++)
      ram[a] = (ph == 0) ? (16'h0C00 | 16'(a)) : (ph == 2) ? 16'h9F41 : 16'h1F41;
    for (int i = 0; i < 2048; i++)
      font[i] = (ph == 0) ? 8'h80 : (ph == 1) ? ((i % 8 < 4) ? 8'hFF : 8'h00) :
                (ph == 2) ? 8'hFF : 8'h00;
    if (ph == 3) begin
      cen = 1'b1;  ccol = 8'd2;  crow = 8'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 16'h0000;
    set_phase(0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    at_edge(2);    chk("lit_vis_edge2", int'(visible), 0);
    at_edge(3);    chk("lit_vis_edge3", int'(visible), 1);
                   chk("lit_fg_first_px", int'(r), 31);
    at_edge(4);    chk("lit_bg_second_px", int'(r), 0);
    at_edge(36);   chk("lit_hs_before", int'(hsync), 0);
    at_edge(37);   chk("lit_hs_start", int'(hsync), 1);
    at_edge(40);   chk("lit_hs_last", int'(hsync), 1);
    at_edge(41);   chk("lit_hs_after", int'(hsync), 0);
    at_edge(325);  chk("lit_addr_row1", int'(scr_rdaddr), 4);
    at_edge(333);  chk("lit_addr_row1_col1", int'(scr_rdaddr), 5);
    at_edge(682);  chk("lit_vs_before", int'(vsync), 0);
    at_edge(683);  chk("lit_vs_start", int'(vsync), 1);
                   chk("lit_vblank", int'(vblank), 1);
    at_edge(700);  set_phase(1);
    at_edge(808);  chk("lit_white", int'({r, g, b}), int'({5'd31, 6'd63, 5'd31}));
    at_edge(810);  chk("lit_vis_per_frame", vis_cnt, 512);
    at_edge(1008); chk("lit_bg1", int'({r, g, b}), int'({5'd0, 6'd0, 5'd21}));
    at_edge(1500); set_phase(2);
    at_edge(1608); chk("lit_blink_off", int'({r, g, b}), int'({5'd0, 6'd0, 5'd21}));
    at_edge(3208); chk("lit_blink_on", int'({r, g, b}), int'({5'd31, 6'd63, 5'd31}));
    at_edge(4700); set_phase(3);
    at_edge(5379); chk("lit_cursor_hidden", int'(b), 21);
                   chk("lit_cursor_hidden_r", int'(r), 0);
    at_edge(6939); chk("lit_cursor_gl5", int'(r), 0);
    at_edge(6979); chk("lit_cursor_shown", int'({r, g, b}), int'({5'd31, 6'd63, 5'd31}));
    at_edge(6987); chk("lit_cursor_next_cell", int'(r), 0);

    first_run = 1'b0;
    at_edge(8020); chk("lit_pre_reset_b", int'(b), 21);
    #2 rst_n = 1'b0;
    #1 chk("lit_async_b", int'(b), 0);
       chk("lit_async_vis", int'(visible), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    at_edge(2);    chk("lit_rel_vis_edge2", int'(visible), 0);
    at_edge(3);    chk("lit_rel_vis_edge3", int'(visible), 1);
                   chk("lit_rel_bg", int'(b), 21);
    at_edge(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/txtd_param.md
Name: txtd_param

Overview:
- Parametrised text-mode video generator; successor to the fixed 1440x900 text display.
- Generates hsync/vsync from a single pixel clock (line counter no longer clocked by hsync) and fetches character/attribute words from external screen RAM and glyph rows from external font ROM, both through 1-cycle synchronous read ports.
- Produces RGB565 from a 16-colour palette, with character blink and a hardware underline cursor.
- Sits between the CPU-writable screen RAM/font ROM and the video output pins.

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch (pixels)
- H_SYNC, 152, hsync width (pixels)
- H_BP, 232, horizontal back porch (pixels)
- V_ACTIVE, 900, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 25, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- GLYPH_LOG2, 4, glyph height = 2**GLYPH_LOG2 lines
- SCALE_LOG2, 1, horizontal pixel replication; cell width = 8<<SCALE_LOG2
- COLS, 90, text columns per row = H_ACTIVE>>(3+SCALE_LOG2)
- ADDR_W, 13, screen RAM address width
- BLINK_LOG2, 5, blink period = 2**(BLINK_LOG2+1) frames

Ports:
- pixel_clock  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cursor_en  in  1  cursor enable
- cursor_col  in  8  cursor column
- cursor_row  in  8  cursor text row
- scr_rdaddr  out  ADDR_W  screen RAM read address (combinational from counters)
- scr_rddata  in  16  screen word, valid 1 clock after address; [7:0] char, [11:8] fg, [14:12] bg, [15] blink
- fnt_rdaddr  out  8+GLYPH_LOG2  {char, glyph_line}; combinational from scr_rddata and delayed glyph_line
- fnt_rddata  in  8  glyph row, valid 1 clock after address; bit 7 = leftmost pixel
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- r  out  5  red
- g  out  6  green
- b  out  5  blue
- visible  out  1  active-video flag
- vblank  out  1  high while line_count >= V_ACTIVE (aligned with the other outputs)

Behaviour:
- Counters:
  - pixel_count runs 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - line_count advances when pixel_count wraps and runs 0..V_TOTAL-1.
  - frame_cnt (BLINK_LOG2+1 bits) increments when line_count wraps.
- Sync: hsync is active for pixel_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is active for line_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Inactive level = ~POL.
- Text addressing:
  - col = pixel_count>>(3+SCALE_LOG2).
  - glyph_line advances at each line wrap while line_count < V_ACTIVE, and wraps at 2**GLYPH_LOG2.
  - row_base adds COLS when glyph_line wraps.
  - row_base, glyph_line and text_row clear at frame wrap.
  - scr_rdaddr = row_base + col (ADDR_W bits, modulo). It is driven for every pixel, blanking included.
  - No multiplier is used.
- Pipeline (fixed latency 3 clocks, counter to pins):
  - T0: scr_rdaddr issued.
  - T1: scr_rddata is used to form fnt_rdaddr; attribute, sub-pixel index, cursor-hit and visibility are delayed one stage.
  - T2: fnt_rddata is sampled; pixel bit = fnt_rddata[7 - ((pixel_count>>SCALE_LOG2) & 7)] (delayed index).
  - The T3 register drives r, g, b, visible, hsync, vsync and vblank.
  - Sync outputs are delayed by the same 3 stages, so video and sync stay aligned.
- Pixel select:
  - on = bit & ~(blink_attr & frame_cnt[BLINK_LOG2]).
  - Cursor hit: cursor_en, col==cursor_col, text_row==cursor_row, glyph_line >= 2**GLYPH_LOG2-2, and frame_cnt[BLINK_LOG2]==0. A cursor hit forces on=1.
  - index = on ? fg : {0,bg}.
- Palette (index {I,R,G,B}):
  - each 5-bit channel = c ? (I ? 31 : 21) : (I ? 10 : 0);
  - g uses 63 / 42 / 21 / 0.
- When not visible: r = g = b = 0 regardless of data.
- Reset (async, any time, including mid-line):
  - all counters and pipeline registers clear;
  - hsync = ~HS_POL, vsync = ~VS_POL, r = g = b = 0, visible = 0, vblank = 0.
  - After release: the counter is at pixel 0/line 0 on the first edge, and visible=1 first appears on the 3rd rising edge after release.
- Frame wrap and line wrap coincide at the final pixel: row_base clears and glyph_line clears; there is no COLS increment that cycle.

Test Plan:
- Small timing (H_ACTIVE=32, H_FP=2, H_SYNC=4, H_BP=2, V_ACTIVE=16, V_FP=1, V_SYNC=2, V_BP=1, SCALE_LOG2=0, GLYPH_LOG2=3, COLS=4) -> hsync high for output cycles 37..40 of each 40-clock line (counter 34..37 +3); vsync high for lines 17,18; visible 32 clocks per line, 16 lines per frame.
- Same config, RAM model returns addr, font model returns 0x80 -> scr_rdaddr sequence 0,..,3 on lines 0-7 and 4..7 on lines 8-15; only the first pixel of each cell is fg.
- Word 0x1F41 with font row 0xFF -> all 8 pixels r=31, g=63, b=31 (fg F); font row 0x00 -> r=0, g=0, b=21 (bg 1).
- Blink bit set, BLINK_LOG2=1 -> glyph shown on frames 0-1, background only on frames 2-3, repeating.
- cursor_en=1, col 2, row 1, font 0x00 -> glyph lines 6,7 of that cell forced to fg on frames where frame_cnt[BLINK_LOG2]=0; no other cell affected.
- Assert reset_n=0 mid-line for 5 clocks -> outputs go to reset values immediately (async); after release, visible rises exactly 3 clocks later at counter pixel 0.
